// File: rtl/poly_mult_ctrl_pkg.sv
// Shared constants, op codes, state encoding and status-word packing for the
// sparse polynomial multiplier command sequencer.
package poly_mult_ctrl_pkg;

  localparam int WEIGHT      = 66;
  localparam int LOGW        = 16;
  localparam int RAMWIDTH    = 32;
  localparam int VEC_WORDS   = 553;
  localparam int RES_WORDS   = 553;
  localparam int ADDR_W      = 10;
  localparam int CYC_W       = 24;
  localparam int TIMEOUT_DEF = 2**24 - 1;

  localparam int POS_IDX_W = $clog2(WEIGHT);

  // Address limits carry the extra status-select bit so that a status-space
  // address never passes a write range check.
  localparam logic [ADDR_W:0] POS_LIMIT = WEIGHT[ADDR_W:0];
  localparam logic [ADDR_W:0] VEC_LIMIT = VEC_WORDS[ADDR_W:0];
  localparam logic [ADDR_W:0] RES_LIMIT = RES_WORDS[ADDR_W:0];

  localparam int STAT_ERR_BIT  = 31;
  localparam int STAT_CODE_LSB = 29;
  localparam int STAT_CYC_LSB  = 0;

  typedef enum logic [1:0] {
    OP_WR_POS = 2'b00,
    OP_WR_VEC = 2'b01,
    OP_START  = 2'b10,
    OP_READ   = 2'b11
  } cmd_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_RD1,
    S_RD2
  } ctrl_state_t;

  localparam logic [1:0] CODE_IDLE = 2'd0;
  localparam logic [1:0] CODE_RUN  = 2'd1;
  localparam logic [1:0] CODE_DONE = 2'd2;
  localparam logic [1:0] CODE_RD   = 2'd3;

  function automatic logic [1:0] state_code(ctrl_state_t s);
    case (s)
      S_IDLE:  return CODE_IDLE;
      S_RUN:   return CODE_RUN;
      S_DONE:  return CODE_DONE;
      default: return CODE_RD;
    endcase
  endfunction

  function automatic logic [RAMWIDTH-1:0] pack_status(logic err, logic [1:0] code,
                                                      logic [CYC_W-1:0] cyc);
    logic [RAMWIDTH-1:0] w;
    w = '0;
    w[STAT_ERR_BIT]             = err;
    w[STAT_CODE_LSB +: 2]       = code;
    w[STAT_CYC_LSB +: CYC_W]    = cyc;
    return w;
  endfunction

endpackage

// File: rtl/poly_mult_ctrl_if.sv
// Host command / read-response bus between a host (master) and the
// multiplier command sequencer (slave).
interface poly_mult_ctrl_if;
  import poly_mult_ctrl_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [ADDR_W:0]     cmd_addr;
  logic [RAMWIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic [RAMWIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/poly_mult_ctrl_timer.sv
// Run-time cycle counter with synchronous clear, enable and saturation, plus
// the timeout compare used to abort a run that never reports valid.
module poly_mult_ctrl_timer
  import poly_mult_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CYC_W-1:0] cycles,
  output logic             timeout
);

  localparam logic [CYC_W-1:0] LIMIT = CYC_W'(TIMEOUT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // in the design samples its inputs as they stood before the clock edge.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cycles <= '0;
    end else if (en && (cycles != '1)) begin
      cycles <= cycles + CYC_W'(1);
    end
  end

  assign timeout = (cycles >= LIMIT);

endmodule

// File: rtl/poly_mult_ctrl.sv
// Command sequencer for the sparse polynomial multiplier: loads position and
// vector RAMs, gates the core start on a complete position set, times the run
// and serves result/status reads.
module poly_mult_ctrl
  import poly_mult_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  poly_mult_ctrl_if.slave     bus,
  output logic                pos_we,
  output logic [ADDR_W-1:0]   pos_addr,
  output logic [LOGW-1:0]     pos_data,
  output logic                vec_we,
  output logic [ADDR_W-1:0]   vec_addr,
  output logic [RAMWIDTH-1:0] vec_data,
  output logic                core_start,
  input  logic                core_valid,
  output logic [ADDR_W-1:0]   core_rd_addr,
  input  logic [RAMWIDTH-1:0] core_dout,
  output logic                busy_o,
  output logic                err_o
);

  ctrl_state_t         state;
  ctrl_state_t         rd_origin;
  logic [WEIGHT-1:0]   bitmap;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic                rsp_sel_core;
  logic                rd_status;
  logic                rd_core_ok;
  logic [RAMWIDTH-1:0] rsp_word;
  logic [CYC_W-1:0]    cycles;
  logic                timeout;

  cmd_op_t         op;
  logic [ADDR_W:0] addr;
  logic            accept;
  logic            pos_ok;
  logic            vec_ok;
  logic            res_ok;
  logic            start_ok;
  logic            tmr_clr;
  logic            tmr_en;

  assign op       = cmd_op_t'(bus.cmd_op);
  assign addr     = bus.cmd_addr;
  assign accept   = bus.cmd_valid && cmd_ready_q;
  assign pos_ok   = (addr < POS_LIMIT);
  assign vec_ok   = (addr < VEC_LIMIT);
  assign res_ok   = (state == S_DONE) && (addr < RES_LIMIT);
  assign start_ok = &bitmap;

  // The counter freezes on the edge that leaves RUN, so DONE reports the
  // cycles elapsed up to (not including) the valid/timeout edge.
  assign tmr_clr = accept && (op == OP_START) && start_ok;
  assign tmr_en  = (state == S_RUN) && !core_valid && !timeout;

  poly_mult_ctrl_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .cycles  (cycles),
    .timeout (timeout)
  );

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_sel_core ? core_dout : rsp_word;

  // NOTE: the position bitmap is a small register array and is reset with
  // the FSM; the external position/vector RAMs are never cleared here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rd_origin    <= S_IDLE;
      bitmap       <= '0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_sel_core <= 1'b0;
      rd_status    <= 1'b0;
      rd_core_ok   <= 1'b0;
      rsp_word     <= '0;
      pos_we       <= 1'b0;
      pos_addr     <= '0;
      pos_data     <= '0;
      vec_we       <= 1'b0;
      vec_addr     <= '0;
      vec_data     <= '0;
      core_start   <= 1'b0;
      core_rd_addr <= '0;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      pos_we      <= 1'b0;
      vec_we      <= 1'b0;
      core_start  <= 1'b0;
      cmd_ready_q <= (state == S_IDLE) || (state == S_DONE);

      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            case (op)
              OP_WR_POS: begin
                state <= S_IDLE;
                if (pos_ok) begin
                  pos_we   <= 1'b1;
                  pos_addr <= addr[ADDR_W-1:0];
                  pos_data <= bus.cmd_data[LOGW-1:0];
                  bitmap[addr[POS_IDX_W-1:0]] <= 1'b1;
                end else begin
                  err_o <= 1'b1;
                end
              end
              OP_WR_VEC: begin
                state <= S_IDLE;
                if (vec_ok) begin
                  vec_we   <= 1'b1;
                  vec_addr <= addr[ADDR_W-1:0];
                  vec_data <= bus.cmd_data;
                end else begin
                  err_o <= 1'b1;
                end
              end
              OP_START: begin
                if (start_ok) begin
                  core_start  <= 1'b1;
                  state       <= S_RUN;
                  busy_o      <= 1'b1;
                  cmd_ready_q <= 1'b0;
                end else begin
                  err_o <= 1'b1;
                end
              end
              OP_READ: begin
                rd_origin    <= state;
                state        <= S_RD1;
                busy_o       <= 1'b1;
                cmd_ready_q  <= 1'b0;
                core_rd_addr <= addr[ADDR_W-1:0];
                rd_status    <= addr[ADDR_W];
                rd_core_ok   <= !addr[ADDR_W] && res_ok;
                if (!addr[ADDR_W] && !res_ok) err_o <= 1'b1;
              end
            endcase
          end
        end

        S_RUN: begin
          cmd_ready_q <= 1'b0;
          if (core_valid) begin
            state       <= S_DONE;
            busy_o      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end else if (timeout) begin
            state       <= S_IDLE;
            err_o       <= 1'b1;
            busy_o      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end

        // The core read address was presented in RD1; its data lands during RD2.
        S_RD1: begin
          state        <= S_RD2;
          cmd_ready_q  <= 1'b0;
          rsp_valid_q  <= 1'b1;
          rsp_sel_core <= rd_core_ok;
          rsp_word     <= rd_status ? pack_status(err_o, state_code(rd_origin), cycles) : '0;
        end

        S_RD2: begin
          state        <= rd_origin;
          cmd_ready_q  <= 1'b1;
          rsp_valid_q  <= 1'b0;
          rsp_sel_core <= 1'b0;
          rsp_word     <= '0;
          busy_o       <= 1'b0;
        end

        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/poly_mult_ctrl.md
Name: poly_mult_ctrl

Overview:
Command sequencer between the host bus and the sparse polynomial multiplier core. It takes 32-bit host commands and from them:
- loads the shift-position RAM and the random-vector RAM;
- checks that all WEIGHT positions are present, then pulses the core start;
- measures run time with a timeout guard;
- serves result-word and status reads once the core reports valid.

It replaces the ad-hoc key/data decoding at the multiplier top level with an explicit handshake and state machine.

Parameters:
WEIGHT, 66, number of shift positions (position RAM depth)
LOGW, 16, position value width
RAMWIDTH, 32, vector/result word width
VEC_WORDS, 553, random-vector words accepted (ceil(N/RAMWIDTH))
RES_WORDS, 553, result words readable
ADDR_W, 10, command address and RAM address width
CYC_W, 24, run cycle counter width
TIMEOUT, 2**24-1, run cycles before abort

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  host command valid
cmd_ready  out  1  controller accepts command this cycle
cmd_op  in  2  00 WR_POS, 01 WR_VEC, 10 START, 11 READ
cmd_addr  in  ADDR_W+1  word address; for READ, bit ADDR_W=1 selects status
cmd_data  in  RAMWIDTH  write data
rsp_valid  out  1  one-cycle read response strobe
rsp_data  out  RAMWIDTH  read response
pos_we / pos_addr / pos_data  out  1 / ADDR_W / LOGW  position RAM write port
vec_we / vec_addr / vec_data  out  1 / ADDR_W / RAMWIDTH  vector RAM write port
core_start  out  1  one-cycle start pulse to multiplier
core_valid  in  1  multiplier result ready (level)
core_rd_addr  out  ADDR_W  result read address
core_dout  in  RAMWIDTH  result word, 1-cycle read latency
busy_o  out  1  high in RUN and during pending reads
err_o  out  1  sticky error flag

Behaviour:
- Reset: every output is 0, state is IDLE, position bitmap, cycle counter and err_o are all cleared. A reset during RUN aborts immediately; core_start stays 0.
- Handshake: a command is accepted when cmd_valid and cmd_ready are both high. cmd_ready=1 only in IDLE or DONE with no read pending.
- States: IDLE, RUN, DONE, RD1, RD2.
- WR_POS (IDLE/DONE):
  - addr<WEIGHT: cycle after accept has pos_we=1 for one cycle, pos_data=cmd_data[LOGW-1:0], bitmap[addr] set.
  - Otherwise: err_o set, no write.
  - Rewriting the same address is legal.
  - Accepted in DONE: state goes to IDLE.
- WR_VEC: same rules against VEC_WORDS, using vec_* and vec_data=cmd_data. The bitmap is not involved.
- START:
  - Bitmap all ones: core_start=1 in the cycle after accept, state RUN, cycle counter cleared.
  - Otherwise: err_o set, state unchanged, no pulse.
  - The bitmap persists across runs; it is cleared only by rst.
- RUN:
  - cmd_ready=0, busy_o=1, counter +1 per cycle; saturates at 2**CYC_W-1.
  - core_valid=1: state DONE, counter frozen.
  - Counter reaches TIMEOUT first: err_o set, state IDLE.
  - core_valid in the same cycle as TIMEOUT: valid wins.
- READ accepted at cycle t:
  - t+1 (RD1): core_rd_addr=addr.
  - t+2 (RD2): rsp_valid=1, rsp_data=core_dout.
  - cmd_ready is 0 in t+1 and t+2; the state then returns to its origin.
- READ rules:
  - Result read is valid only in DONE with addr<RES_WORDS.
  - Otherwise the response still occurs at t+2 with rsp_data=0, and err_o is set.
  - Status read is legal in any non-RUN state: rsp_data={err_o, 2'b state_code, 5'b0, cycles[23:0]}.
  - state_code: IDLE=0, DONE=2.
- err_o clears only on rst.
- Writes never overlap in one cycle: pos_we and vec_we are mutually exclusive.

Decomposition:
- Package poly_mult_ctrl_pkg holds the op codes, the state enum and state_code values, and the derived widths (ADDR_W, CYC_W, status field offsets).
- One sub-module, poly_mult_ctrl_timer: the run cycle counter with clear/enable/saturate, plus the timeout compare.

Test Plan:
1. Write 66 positions (addr i, data 3*i), then START → core_start pulse 1 cycle after accept, busy_o=1, pos_we count=66.
2. Write 65 positions, then START → err_o=1, no core_start, status read returns err=1, state_code=0.
3. Model core raises valid 1000 cycles after start → status reads cycles=1000 (±1 defined by RTL), state_code=2; READ addr 5 returns model word 5 exactly 2 cycles after accept.
4. WR_POS addr 66 and WR_VEC addr 553 → no pos_we/vec_we, err_o=1.
5. TIMEOUT=100, core never valid → at cycle 100 err_o=1, state IDLE, cmd_ready=1.
6. rst asserted mid-RUN → next cycle all outputs 0, state IDLE, bitmap cleared, so START now errors.
